preset_timer: RTL
=================

PRESET_TIMER -- requirements
Module: preset_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 5, counter/data width, legal range 2..32.
REQ-002 SHALL have parameter PS_WIDTH, default 8, prescaler divisor width, used only when PRESCALER_EN is defined.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port load  input  1  capture data as the reload value and go to IDLE.
REQ-006 SHALL have port dir  input  1  0 = count down, 1 = count up; sampled only on load.
REQ-007 SHALL have port data  input  WIDTH  reload value.
REQ-008 SHALL have port start  input  1  begin counting from IDLE or DONE.
REQ-009 SHALL have port stop  input  1  halt counting and hold the current count.
REQ-010 SHALL have port auto_reload  input  1  1 = periodic, 0 = one-shot; sampled only on start.
REQ-011 SHALL have port count  output  WIDTH  current count.
REQ-012 SHALL have port tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-013 SHALL have port busy  output  1  high while in RUN.
REQ-014 SHALL have port done  output  1  high while in DONE.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE.
REQ-016 SHALL apply control priority per edge: load > stop > start > count step.
REQ-017 On load, from any state: reload_reg <= data, dir latched, state -> IDLE; count <= data if down, 0 if up; tc <= 0.
REQ-018 On stop in RUN: state -> IDLE with count held; in IDLE/DONE stop has no effect.
REQ-019 On start in IDLE or DONE: state -> RUN and auto_reload latched; count is reinitialised to its load value only when coming from DONE. start while in RUN is ignored.
REQ-020 In RUN, on each tick: count steps by -1 (down) or +1 (up), modulo 2^WIDTH.
REQ-021 Terminal value SHALL be 0 when counting down and reload_reg when counting up.
REQ-022 On a tick with count == terminal:
  - the step is replaced by terminal handling;
  - tc = 1 for the following cycle only;
  - if auto_reload, count is reinitialised and state stays RUN;
  - otherwise state -> DONE and count holds.
REQ-023 Period SHALL be reload_reg+1 ticks, including reload_reg = 0: tc every tick when periodic, after one tick when one-shot.
REQ-024 busy and done SHALL be decoded from registered state: no combinational path from any input to any output.
REQ-025 When a load or stop coincides with a terminal tick, no tc is produced.

Reset
REQ-026 While rst is high, the following SHALL be forced immediately, independent of clk: count = 0, reload_reg = 0, dir = down, auto_reload latch = 0, state = IDLE, tc = 0, busy = 0, done = 0, prescaler count = 0.
REQ-027 Reset asserted mid-RUN SHALL abandon the run; no tc is emitted on release.

Configuration
REQ-028 Macro PRESCALER_EN SHALL control the prescaler.
  - Defined: input ps_div [PS_WIDTH-1:0] is present, and tick asserts once every ps_div+1 clocks while in RUN. The prescaler count clears on load, start, stop and terminal handling.
  - Undefined: ps_div is absent and tick = 1 on every clock.

Structure
REQ-029 The shared package timer_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the dir encoding constants DIR_DOWN and DIR_UP.
REQ-030 The prescaler SHALL be the sub-module tick_prescaler, instantiated only under PRESCALER_EN; all other logic stays in preset_timer.

Verification (WIDTH=8, macro undefined unless stated)
REQ-031 Load data=5 with dir=0, then start with auto_reload=0: count is 5,4,3,2,1,0; tc is one cycle wide on the 6th RUN edge; done=1; count holds 0.
REQ-032 Load data=3 with dir=1, then start with auto_reload=1: count repeats 0,1,2,3,0,1,…; tc pulses every 4 clocks; busy stays 1.
REQ-033 Load data=0, then start with auto_reload=1: tc=1 continuously from the 2nd RUN cycle; count stays 0.
REQ-034 Down run from 9; when count=2, assert load with data=7: next cycle count=7, IDLE, busy=0, tc never asserted.
REQ-035 Assert rst between clock edges mid-run at count=4: count, busy and tc are 0 before the next edge; after release, state is IDLE.
REQ-036 With PRESCALER_EN and ps_div=2: load 4 down, start; count changes every 3 clocks; tc arrives 15 clocks after RUN entry.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and count-direction constants for preset_timer.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: emits one tick every ps_div+1 clocks while run is high.
// Used by preset_timer only when PRESCALER_EN is defined.
module tick_prescaler #(
   parameter int PS_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                clear,
   input  logic [PS_WIDTH-1:0] ps_div,
   output logic                tick
);

   logic [PS_WIDTH-1:0] ps_cnt;

   assign tick = run && (ps_cnt == ps_div);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps_cnt <= '0;
      end else if (clear || tick) begin
         ps_cnt <= '0;
      end else if (run) begin
         ps_cnt <= ps_cnt + PS_WIDTH'(1);
      end
   end

endmodule

// File: rtl/preset_timer.sv
// preset_timer: loadable up/down timer, one-shot or periodic, with a registered one-cycle tc pulse.
// Define PRESCALER_EN to add the ps_div input and slow the count tick through tick_prescaler.
module preset_timer
   import timer_pkg::*;
#(
   parameter int WIDTH    = 5,
   parameter int PS_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                dir,
   input  logic [WIDTH-1:0]    data,
   input  logic                start,
   input  logic                stop,
   input  logic                auto_reload,
`ifdef PRESCALER_EN
   input  logic [PS_WIDTH-1:0] ps_div,
`endif
   output logic [WIDTH-1:0]    count,
   output logic                tc,
   output logic                busy,
   output logic                done
);

   if (WIDTH < 2 || WIDTH > 32 || PS_WIDTH < 1) begin : g_param_check
      $error("preset_timer: WIDTH must be 2..32 and PS_WIDTH at least 1");
   end

   state_t           state, state_nxt;
   logic [WIDTH-1:0] reload_reg, reload_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             dir_q, dir_nxt;
   logic             auto_q, auto_nxt;
   logic             tc_nxt;
   logic             tick;
   logic [WIDTH-1:0] term_val;
   logic [WIDTH-1:0] init_val;
   logic             at_term;

   // Up-counting runs 0 -> reload_reg, down-counting runs reload_reg -> 0.
   assign term_val = (dir_q == DIR_UP) ? reload_reg : '0;
   assign init_val = (dir_q == DIR_UP) ? '0 : reload_reg;
   assign at_term  = (count == term_val);

`ifdef PRESCALER_EN
   logic ps_clear;

   assign ps_clear = load || stop || (start && state != RUN) ||
                     (state == RUN && tick && at_term);

   tick_prescaler #(
      .PS_WIDTH (PS_WIDTH)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .run    (state == RUN),
      .clear  (ps_clear),
      .ps_div (ps_div),
      .tick   (tick)
   );
`else
   assign tick = 1'b1;
`endif

   // NOTE: every variable gets its default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      reload_nxt = reload_reg;
      dir_nxt    = dir_q;
      auto_nxt   = auto_q;
      tc_nxt     = 1'b0;

      if (load) begin
         reload_nxt = data;
         dir_nxt    = dir;
         state_nxt  = IDLE;
         count_nxt  = (dir == DIR_UP) ? '0 : data;
      end else if (stop) begin
         if (state == RUN) begin
            state_nxt = IDLE;
         end
      end else if (start && state != RUN) begin
         state_nxt = RUN;
         auto_nxt  = auto_reload;
         if (state == DONE) begin
            count_nxt = init_val;
         end
      end else if (state == RUN && tick) begin
         if (at_term) begin
            tc_nxt = 1'b1;
            if (auto_q) begin
               count_nxt = init_val;
            end else begin
               state_nxt = DONE;
            end
         end else if (dir_q == DIR_UP) begin
            count_nxt = count + WIDTH'(1);
         end else begin
            count_nxt = count - WIDTH'(1);
         end
      end
   end

   // NOTE: registers use non-blocking assignments so all of them sample pre-edge values together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         reload_reg <= '0;
         dir_q      <= DIR_DOWN;
         auto_q     <= 1'b0;
         tc         <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         reload_reg <= reload_nxt;
         dir_q      <= dir_nxt;
         auto_q     <= auto_nxt;
         tc         <= tc_nxt;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule
